// File: rtl/crc_stream.sv
// Streaming CRC engine: accepts one DATA_W word per N+1 cycles and chains
// BPC unaugmented LFSR steps per clock. Frames span many words and are
// delimited by in_first/in_last; the finished CRC is published with a
// one-cycle crc_valid strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a word, in_ready=1
// BUSY  | shifting the captured word through the LFSR, N = DATA_W/BPC edges
module crc_stream #(
  parameter int              DATA_W  = 32,
  parameter int              CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit              REFIN   = 1'b1,
  parameter bit              REFOUT  = 1'b1,
  parameter int              BPC     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc,
  output logic              crc_valid,
  output logic              busy
);

  localparam int N     = (BPC == 0) ? 1 : DATA_W / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (BPC == 0 || BPC > DATA_W || (DATA_W % BPC) != 0 || CRC_W < 8 || CRC_W > 64)
  begin : g_param_check
    $fatal(1, "crc_stream: illegal DATA_W/BPC/CRC_W combination");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   lfsr_q, lfsr_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               crc_valid_q, crc_valid_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CRC_W-1:0]   lfsr_next;
  logic [DATA_W-1:0]  sreg_next;
  logic [CRC_W-1:0]   lfsr_rev;

  // BPC chained LFSR steps; bits leave the shift register LSB or MSB first
  always_comb begin : p_step
    logic b;
    logic fb;
    lfsr_next = lfsr_q;
    sreg_next = sreg_q;
    for (int i = 0; i < BPC; i++) begin
      if (REFIN) begin
        b         = sreg_next[0];
        sreg_next = sreg_next >> 1;
      end else begin
        b         = sreg_next[DATA_W-1];
        sreg_next = sreg_next << 1;
      end
      fb        = lfsr_next[CRC_W-1] ^ b;
      lfsr_next = {lfsr_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // Bit-reversed view of the final register value for REFOUT
  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < CRC_W; i++) begin
      lfsr_rev[i] = lfsr_next[CRC_W-1-i];
    end
  end

  // Next-state, datapath updates and result publication; clr overrides all
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    crc_d       = crc_q;
    crc_valid_d = 1'b0;
    sreg_d      = sreg_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (clr) begin
      state_d = IDLE;
      lfsr_d  = INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = BUSY;
            sreg_d  = in_data;
            last_d  = in_last;
            cnt_d   = CNT_W'(N - 1);
            if (in_first) begin
              lfsr_d = INIT;
            end
          end
        end
        BUSY: begin
          sreg_d = sreg_next;
          lfsr_d = lfsr_next;
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (last_q) begin
              crc_d       = (REFOUT ? lfsr_rev : lfsr_next) ^ XOR_OUT;
              crc_valid_d = 1'b1;
              lfsr_d      = INIT;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_q      <= INIT;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      sreg_q      <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
      sreg_q      <= sreg_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !clr;
  assign busy      = (state_q == BUSY);
  assign crc       = crc_q;
  assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: three instances (CRC-32, CRC-32/MPEG-2 with BPC=4,
// CRC-16/CCITT-FALSE with BPC=8), all with byte-wide input.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  vld = '0;
  wire  [2:0]  rdy;
  wire  [2:0]  cv;
  wire  [2:0]  bsy;
  wire  [31:0] crc_a;
  wire  [31:0] crc_b;
  wire  [15:0] crc_c;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int nstb[3]    = '{0, 0, 0};
  int stb_cyc[3] = '{0, 0, 0};
  logic [31:0] stb_crc[3];
  int nsel[3] = '{8, 2, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_stream #(.DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .crc(crc_a), .crc_valid(cv[0]), .busy(bsy[0]));

  crc_stream #(.DATA_W(8), .BPC(4), .REFIN(1'b0), .REFOUT(1'b0), .XOR_OUT(32'h0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .crc(crc_b), .crc_valid(cv[1]), .busy(bsy[1]));

  crc_stream #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0),
               .REFIN(1'b0), .REFOUT(1'b0), .BPC(8)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .crc(crc_c), .crc_valid(cv[2]), .busy(bsy[2]));

  function automatic logic [31:0] get_crc(input int sel);
    case (sel)
      0: return crc_a;
      1: return crc_b;
      default: return {16'h0, crc_c};
    endcase
  endfunction

  // Textbook byte-wise CRC definitions for the three configurations
  function automatic logic [31:0] ref_crc(input int sel, input logic [7:0] q[$]);
    logic [31:0] c;
    logic [15:0] h;
    if (sel == 0) begin
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
        c = c ^ {24'h0, q[i]};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
    end else if (sel == 1) begin
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
        c = c ^ {q[i], 24'h0};
        repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return c;
    end else begin
      h = 16'hFFFF;
      foreach (q[i]) begin
        h = h ^ {q[i], 8'h0};
        repeat (8) h = h[15] ? ((h << 1) ^ 16'h1021) : (h << 1);
      end
      return {16'h0, h};
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor, sampled 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      if (cv[k] === 1'b1) begin
        nstb[k]++;
        stb_crc[k] = get_crc(k);
        stb_cyc[k] = cyc;
        chk("strobe_with_ready", {63'h0, rdy[k]}, 64'h1);
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] d, input logic f, input logic l);
    int k;
    @(negedge clk);
    in_data = d; in_first = f; in_last = l; vld[sel] = 1'b1;
    for (k = 0; k < 40 && rdy[sel] !== 1'b1; k++) @(negedge clk);
    chk("ready_timeout", {63'h0, rdy[sel]}, 64'h1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    vld[sel] = 1'b0;
  endtask

  task automatic wait_strobe(input int sel, input int prev);
    for (int k = 0; k < 100 && nstb[sel] == prev; k++) @(negedge clk);
  endtask

  typedef struct {
    int          sel;
    int          len;
    logic [71:0] msg;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p0, prev_acc, last_acc, k, prev_rdy, n_acc;
    logic [31:0] held;
    logic [7:0] q[$];

    vecs[0] = '{0, 9, "123456789", 32'hCBF43926};
    vecs[1] = '{0, 3, "abc",       32'h352441C2};
    vecs[2] = '{0, 1, "a",         32'hE8B7BE43};
    vecs[3] = '{1, 9, "123456789", 32'h0376E6E7};
    vecs[4] = '{2, 9, "123456789", 32'h000029B1};

    // reset values
    #22;
    chk("rst_ready", {61'h0, rdy}, 64'h7);
    chk("rst_busy", {61'h0, bsy}, 64'h0);
    chk("rst_crc_valid", {61'h0, cv}, 64'h0);
    chk("rst_crc_a", {32'h0, crc_a}, 64'h0);
    chk("rst_crc_c", {48'h0, crc_c}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // table-driven known check values
    for (int v = 0; v < 5; v++) begin
      p0 = nstb[vecs[v].sel];
      prev_acc = 0;
      last_acc = 0;
      for (int i = 0; i < vecs[v].len; i++) begin
        send(vecs[v].sel, vecs[v].msg[8*(vecs[v].len-1-i) +: 8], i == 0, i == vecs[v].len - 1);
        prev_acc = last_acc;
        last_acc = acc_cyc;
      end
      wait_strobe(vecs[v].sel, p0);
      repeat (3) @(negedge clk);
      chk("vec_crc", {32'h0, get_crc(vecs[v].sel)}, {32'h0, vecs[v].exp});
      chk("vec_strobes", 64'(nstb[vecs[v].sel] - p0), 64'd1);
      chk("vec_latency", 64'(stb_cyc[vecs[v].sel] - last_acc), 64'(nsel[vecs[v].sel]));
      if (vecs[v].len > 1)
        chk("vec_throughput", 64'(last_acc - prev_acc), 64'(nsel[vecs[v].sel] + 1));
    end

    // aborted "12345" followed by a fresh full frame
    p0 = nstb[0];
    for (int i = 0; i < 5; i++) send(0, 8'h31 + 8'(i), i == 0, 1'b0);
    for (int i = 0; i < 9; i++) send(0, 8'h31 + 8'(i), i == 0, i == 8);
    wait_strobe(0, p0);
    repeat (10) @(negedge clk);
    chk("abort_strobes", 64'(nstb[0] - p0), 64'd1);
    chk("abort_crc", {32'h0, crc_a}, {32'h0, 32'hCBF43926});

    // in_valid held high: ready period N+1, single-word frames "1"
    p0 = nstb[0];
    prev_rdy = -1;
    n_acc = 0;
    @(negedge clk);
    in_data = 8'h31; in_first = 1'b1; in_last = 1'b1; vld[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rdy[0] === 1'b1) begin
        if (prev_rdy >= 0) chk("ready_period", 64'(cyc - prev_rdy), 64'd9);
        prev_rdy = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    vld[0] = 1'b0;
    repeat (12) @(negedge clk);
    q.delete();
    q.push_back(8'h31);
    chk("stream_strobes", 64'(nstb[0] - p0), 64'(n_acc));
    chk("stream_crc", {32'h0, crc_a}, {32'h0, ref_crc(0, q)});
    held = crc_a;

    // clr mid-BUSY
    p0 = nstb[0];
    for (int i = 0; i < 4; i++) send(0, 8'h41 + 8'(i), i == 0, 1'b0);
    @(negedge clk);
    chk("pre_clr_busy", {63'h0, bsy[0]}, 64'h1);
    clr = 1'b1;
    #1;
    chk("clr_ready_low", {63'h0, rdy[0]}, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", {63'h0, bsy[0]}, 64'h0);
    chk("clr_crc_held", {32'h0, crc_a}, {32'h0, held});
    // word offered together with clr is dropped
    clr = 1'b1; vld[0] = 1'b1; in_first = 1'b1; in_last = 1'b1;
    #1;
    chk("clr_ready_low2", {63'h0, rdy[0]}, 64'h0);
    @(negedge clk);
    clr = 1'b0; vld[0] = 1'b0;
    chk("clr_no_accept", {63'h0, bsy[0]}, 64'h0);
    repeat (12) @(negedge clk);
    chk("clr_no_strobe", 64'(nstb[0] - p0), 64'd0);

    // async reset mid-frame
    for (int i = 0; i < 2; i++) send(0, 8'h51 + 8'(i), i == 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", {63'h0, bsy[0]}, 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_crc", {32'h0, crc_a}, 64'h0);
    chk("rst_mid_busy", {63'h0, bsy[0]}, 64'h0);
    chk("rst_mid_ready", {63'h0, rdy[0]}, 64'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_no_strobe", 64'(nstb[0] - p0), 64'd0);
    for (int i = 0; i < 9; i++) send(0, 8'h31 + 8'(i), i == 0, i == 8);
    wait_strobe(0, p0);
    repeat (3) @(negedge clk);
    chk("post_rst_strobes", 64'(nstb[0] - p0), 64'd1);
    chk("post_rst_crc", {32'h0, crc_a}, {32'h0, 32'hCBF43926});

    // randomized frames against the reference model
    for (int it = 0; it < 15; it++) begin
      int sel, len;
      sel = $urandom_range(0, 2);
      p0 = nstb[sel];
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) send(sel, 8'($urandom), i == 0, 1'b0);
      end
      len = $urandom_range(1, 6);
      q.delete();
      for (int i = 0; i < len; i++) begin
        q.push_back(8'($urandom));
        send(sel, q[i], i == 0, i == len - 1);
      end
      wait_strobe(sel, p0);
      repeat (3) @(negedge clk);
      chk("rand_strobes", 64'(nstb[sel] - p0), 64'd1);
      chk("rand_crc", {32'h0, get_crc(sel)}, {32'h0, ref_crc(sel, q)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
